frame_parser: RTL
=================

Name: frame_parser

Overview:
Byte-level frame decoder that sits directly downstream of the UART receiver byte FIFO. It pulls bytes through the FIFO's ready/read handshake and hunts for a start-of-frame byte. It then collects a length-prefixed payload, checks an 8-bit additive checksum, and replays validated payloads to the consumer over a valid/ack stream. Malformed, corrupted or stalled frames are reported as one-cycle error pulses and discarded.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; legal range 1..255; sizes the payload buffer.
TIMEOUT, 46080000, idle clock cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
i_clk  in  1  system clock, rising edge.
i_rst  in  1  asynchronous active-low reset.
i_ready  in  1  receiver FIFO non-empty.
i_D  in  8  receiver FIFO head byte; valid whenever i_ready=1.
o_read  out  1  pop strobe to the receiver FIFO; the byte on i_D is consumed in the same cycle.
o_valid  out  1  payload byte available on o_data.
o_data  out  8  payload byte.
o_last  out  1  o_data is the final payload byte of the frame.
i_ack  in  1  consumer accepts o_data this cycle, when o_valid=1.
o_len  out  8  length of the frame being output; held stable while o_valid=1.
o_done  out  1  one-cycle pulse: the last payload byte was acked.
o_err  out  1  one-cycle pulse: frame discarded.
o_err_code  out  2  cause of the discard, valid with o_err: 1=bad length, 2=checksum mismatch, 3=timeout.
o_busy  out  1  state is not HUNT.

Behaviour:
- Reset: the async assert of i_rst clears all state to HUNT. All outputs are 0, and the buffer, counters and checksum are 0. Reset mid-frame drops the frame silently, with no o_err.
- Frame format on the wire: SOF=0xA5, LEN, LEN payload bytes, CHK. The frame is good when (LEN + sum of payload + CHK) mod 256 = 0.
- o_read = i_ready & (state in HUNT, LEN, PAY, CHK). It is combinational, with no registered lookahead. Back-to-back reads on consecutive cycles are allowed. o_read=0 in OUT, so the FIFO absorbs backpressure.
- A byte is "accepted" in any cycle where o_read=1.
- HUNT: an accepted 0xA5 goes to LEN; any other byte is discarded silently.
- LEN: an accepted byte b goes to PAY if 1 <= b <= MAX_LEN, which sets len=b, sum=b, idx=0. Otherwise it pulses o_err with code 1 and returns to HUNT. A 0xA5 here is treated as a length value, not a resync.
- PAY: an accepted byte is written to buf[idx], with sum += byte (8-bit wrap) and idx++. When idx = len-1 at accept, go to CHK.
- CHK: on accept, if (sum + byte) mod 256 = 0, go to OUT with idx=0. Otherwise pulse o_err with code 2 and go to HUNT.
- OUT: o_valid=1, o_data=buf[idx], o_len=len, o_last=(idx=len-1).
  - On i_ack: idx++.
  - On i_ack with o_last: pulse o_done the next cycle and go to HUNT.
  - i_ack while o_valid=0 is ignored.
- Timeout: a 32-bit idle counter runs in LEN, PAY and CHK.
  - It clears on each accepted byte and on every state entry.
  - When it reaches TIMEOUT-1 with no accept: pulse o_err with code 3, go to HUNT, clear the counter.
  - If a byte is accepted in the same cycle as the timeout hit, the byte wins: no error, counter cleared.
  - The counter is held at 0 in HUNT and OUT.
- Output timing: o_err and o_done are registered, asserted exactly the cycle after the triggering event, and never both high together. o_err_code holds its last value when o_err=0.
- Latency: the first o_valid comes 1 cycle after the CHK byte is accepted.
- The payload buffer is only written in PAY. Its stale contents beyond len are never output.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {HUNT, LEN, PAY, CHK, OUT};
  - localparam SOF=8'hA5;
  - the error-code constants ERR_LEN=2'd1, ERR_CHK=2'd2, ERR_TMO=2'd3.
- One sub-module, frame_buf: a MAX_LEN x 8 register file with a write port (we, waddr, wdata) and an asynchronous read port (raddr -> rdata), with async active-low reset to 0.
- The FSM, checksum, index and timeout counter stay in frame_parser.

Test Plan:
- Good frame: feed A5 03 11 22 33 97 with i_ack=1. Expect o_data 11, 22, 33 on 3 consecutive cycles, o_last only with 33, o_len=3, then an o_done pulse and o_err never asserted.
- Garbage then frame: feed 00 FF 5A A5 01 7E 81. Expect the first three bytes popped with no outputs, then a single byte 7E with o_last=1 and o_done.
- Bad checksum and bad length: A5 03 11 22 33 98 gives o_err code 2 and no o_valid. A5 00 gives o_err code 1. With MAX_LEN=16, A5 11 gives code 1. Each case is followed by a good frame that must decode normally.
- Timeout (TIMEOUT=100): feed A5 02 11 then idle. Expect o_err code 3 exactly 100 cycles after 11 was accepted, and state HUNT. A byte arriving on cycle 99 must not error.
- Backpressure: a good 4-byte frame with i_ack toggled 0/1 and a second frame queued in the FIFO. o_read must stay 0 throughout OUT. Bytes are held stable while un-acked, and the second frame decodes after o_done.
- Reset mid-frame: assert i_rst during PAY. Outputs go to 0 immediately, with no o_err. After release a full good frame decodes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding, start-of-frame marker and discard cause codes.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAY,
        CHK,
        OUT
    } state_t;

    localparam logic [7:0] SOF     = 8'hA5;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

endpackage

// File: rtl/frame_buf.sv
// Payload store: DEPTH x 8 register file, one write port, one async read port.
// Latency: write lands on the next rising edge; read data is combinational.
// Backpressure: none; the owner decides when to write and what to read.
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage: cleared on reset, one byte written per enabled cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_parser.sv
// Frame decoder: hunts SOF, collects LEN-prefixed payload, checks additive sum, replays it.
// Latency: first payload byte is presented 1 cycle after the checksum byte is popped.
// Backpressure: FIFO is not popped while replaying; each byte is held until i_ack.
module frame_parser #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 46080000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ready,
    input  logic [7:0] i_D,
    output logic       o_read,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    input  logic       i_ack,
    output logic [7:0] o_len,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    import uart_pkg::*;

    localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    // cnt_q holds the idle cycles already completed since the last accept or
    // state entry, so the current cycle is idle cycle cnt_q+1; abandon the
    // frame on idle cycle TIMEOUT-1 so the error lands TIMEOUT cycles after
    // the last byte.
    localparam logic [31:0] TMO_LAST  = (TIMEOUT >= 2) ? 32'(TIMEOUT - 2) : 32'd0;

    state_t      state_q, state_d;
    logic [7:0]  len_q, sum_q, idx_q;
    logic [31:0] cnt_q;
    logic        err_q, done_q;
    logic [1:0]  code_q;

    logic        accept, in_rx, tmo_hit, len_ok, chk_ok, idx_last;
    logic [7:0]  chk_sum, rdata;

    assign accept   = o_read;
    assign in_rx    = (state_q == LEN) || (state_q == PAY) || (state_q == CHK);
    assign tmo_hit  = in_rx && !accept && (cnt_q == TMO_LAST);
    assign len_ok   = (i_D != 8'd0) && (i_D <= MAX_LEN_B);
    assign chk_sum  = sum_q + i_D;
    assign chk_ok   = (chk_sum == 8'd0);
    assign idx_last = (idx_q == len_q - 8'd1);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accepted bytes drive the frame walk; an accepted byte beats a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: if (accept && (i_D == SOF)) state_d = LEN;
            LEN: begin
                if (accept)       state_d = len_ok ? PAY : HUNT;
                else if (tmo_hit) state_d = HUNT;
            end
            PAY: begin
                if (accept) begin
                    if (idx_last) state_d = CHK;
                end else if (tmo_hit) begin
                    state_d = HUNT;
                end
            end
            CHK: begin
                if (accept)       state_d = chk_ok ? OUT : HUNT;
                else if (tmo_hit) state_d = HUNT;
            end
            OUT:     if (i_ack && idx_last) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Outputs: pop the FIFO in every state except OUT (never while reset is held); replay from the buffer in OUT.
    always_comb begin
        o_read  = 1'b0;
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_len   = '0;
        if (state_q == OUT) begin
            o_valid = 1'b1;
            o_data  = rdata;
            o_last  = idx_last;
            o_len   = len_q;
        end else begin
            o_read  = i_rst & i_ready;
        end
    end

    // Datapath: length, running sum, byte index, idle counter and registered pulses.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            len_q  <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            code_q <= '0;
        end else begin
            err_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= (in_rx && !accept && !tmo_hit) ? cnt_q + 32'd1 : 32'd0;
            case (state_q)
                LEN: if (accept) begin
                    if (len_ok) begin
                        len_q <= i_D;
                        sum_q <= i_D;
                        idx_q <= '0;
                    end else begin
                        err_q  <= 1'b1;
                        code_q <= ERR_LEN;
                    end
                end
                PAY: if (accept) begin
                    sum_q <= sum_q + i_D;
                    idx_q <= idx_q + 8'd1;
                end
                CHK: if (accept) begin
                    if (chk_ok) begin
                        idx_q <= '0;
                    end else begin
                        err_q  <= 1'b1;
                        code_q <= ERR_CHK;
                    end
                end
                OUT: if (i_ack) begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_last) done_q <= 1'b1;
                end
                default: ;
            endcase
            if (tmo_hit) begin
                err_q  <= 1'b1;
                code_q <= ERR_TMO;
            end
        end
    end

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .we    ((state_q == PAY) && accept),
        .waddr (idx_q[AW-1:0]),
        .wdata (i_D),
        .raddr (idx_q[AW-1:0]),
        .rdata (rdata)
    );

    assign o_busy     = (state_q != HUNT);
    assign o_err      = err_q;
    assign o_done     = done_q;
    assign o_err_code = code_q;

endmodule
